rr_dec_scheduler: RTL and testbench

//  Round-robin scheduler sharing one 4-to-16 one-hot select resource among up
//  to 16 requesters. Grants exactly one requester at a time and holds the grant

---
 rtl/rr_dec_scheduler.sv | 126 ++++++++++++
 tb/tb_rr_dec_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_dec_scheduler.sv
// rr_dec_scheduler: round-robin owner of one 4-to-16 one-hot select, grant held until release.
// Optional macro HOLD_TIMEOUT_EN forces release after MAX_HOLD grant cycles and pulses preempt.
module rr_dec_scheduler #(
    parameter int N_REQ    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_vld,
    output logic        preempt
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] gnt_q, gnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        vld_q, vld_d;
    logic [4:0]  pick_res;
    logic [3:0]  ptr_nxt;

`ifdef HOLD_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic          preempt_q, preempt_d;
`endif

    // First set request at or after p0, wrapping at N_REQ; bit 4 flags "found".
    // Scanning backwards lets the earliest match in ptr order win.
    function automatic logic [4:0] pick(input logic [15:0] r, input logic [3:0] p0);
        logic [4:0] res;
        int         p;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            p = int'(p0) + k;
            if (p >= N_REQ) p -= N_REQ;
            if (r[4'(p)]) res = {1'b1, 4'(p)};
        end
        return res;
    endfunction

    assign pick_res = pick(req, ptr_q);
    assign ptr_nxt  = (idx_q == 4'(N_REQ - 1)) ? 4'd0 : idx_q + 4'd1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        vld_d   = vld_q;
`ifdef HOLD_TIMEOUT_EN
        hold_d    = hold_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_res[4]) begin
                    idx_d   = pick_res[3:0];
                    gnt_d   = 16'd1 << pick_res[3:0];
                    vld_d   = 1'b1;
                    state_d = GRANT;
`ifdef HOLD_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                // ptr advances only on release, so the releaser drops to lowest priority
                if (!req[idx_q]) begin
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    ptr_d   = ptr_nxt;
                    state_d = GAP;
`ifdef HOLD_TIMEOUT_EN
                end else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    gnt_d     = '0;
                    vld_d     = 1'b0;
                    ptr_d     = ptr_nxt;
                    state_d   = GAP;
                    preempt_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            vld_q   <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
            hold_q    <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
`ifdef HOLD_TIMEOUT_EN
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
`ifdef HOLD_TIMEOUT_EN
    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_dec_scheduler.sv
// Bench for rr_dec_scheduler: grant-order scoreboard plus per-scenario timing checks.
// Main DUT uses N_REQ=16, a second instance uses N_REQ=10 for the wrap boundary.
module tb_rr_dec_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
    logic        preempt;
    logic [15:0] req2 = 16'h0;
    logic [15:0] gnt2;
    logic [3:0]  gnt_idx2;
    logic        gnt_vld2;
    logic        preempt2;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] sb_q[$];
    logic       prev_vld = 1'b0;

    rr_dec_scheduler #(.N_REQ(16), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .preempt(preempt)
    );

    rr_dec_scheduler #(.N_REQ(10), .MAX_HOLD(4)) dut10 (
        .clk(clk), .rst(rst), .req(req2), .gnt(gnt2),
        .gnt_idx(gnt_idx2), .gnt_vld(gnt_vld2), .preempt(preempt2)
    );

    always #5 clk = ~clk;

    // Scoreboard: every new grant must match the next expected grantee.
    always @(negedge clk) begin
        logic [3:0] e;
        if (gnt_vld && !prev_vld) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got grant idx=%0d, required no grant", gnt_idx);
            end else begin
                e = sb_q.pop_front();
                if (gnt_idx !== e || gnt !== (16'd1 << e)) begin
                    n_err++;
                    $display("FAIL sb_grant: got idx=%0d gnt=%h, required idx=%0d gnt=%h",
                             gnt_idx, gnt, e, 16'd1 << e);
                end
            end
        end
        n_cmp++;
        if (gnt !== (gnt_vld ? (16'd1 << gnt_idx) : 16'd0)) begin
            n_err++;
            $display("FAIL onehot: got gnt=%h vld=%b idx=%0d", gnt, gnt_vld, gnt_idx);
        end
        prev_vld = gnt_vld;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        req  = 16'h0;
        req2 = 16'h0;
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 16'hFFFF;
        req2 = 16'hFFFF;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (gnt !== 16'h0)   begin n_err++; $display("FAIL rst_gnt: got %h, required 0000", gnt); end
        n_cmp++; if (gnt_idx !== 4'd0) begin n_err++; $display("FAIL rst_idx: got %0d, required 0", gnt_idx); end
        n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b, required 0", gnt_vld); end
        n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL rst_preempt: got %b, required 0", preempt); end
        n_cmp++; if (gnt_vld2 !== 1'b0 || gnt2 !== 16'h0) begin
            n_err++; $display("FAIL rst_dut10: got vld=%b gnt=%h, required 0/0000", gnt_vld2, gnt2);
        end
        req  = 16'h0;
        req2 = 16'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        tick();
        req = 16'h0020;
        sb_q.push_back(4'd5);
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b1 || gnt_idx !== 4'd5 || gnt !== 16'h0020) begin
            n_err++; $display("FAIL basic_latency: got vld=%b idx=%0d gnt=%h, required 1/5/0020", gnt_vld, gnt_idx, gnt);
        end
        repeat (3) tick();
        req = 16'h0;
        @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b1) begin n_err++; $display("FAIL basic_hold: got vld=%b, required 1", gnt_vld); end
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b0 || gnt !== 16'h0) begin
            n_err++; $display("FAIL basic_release: got vld=%b gnt=%h, required 0/0000", gnt_vld, gnt);
        end
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL basic_idle: got vld=%b, required 0", gnt_vld); end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        do_reset();
        req = 16'h8001;
        sb_q.push_back(4'd0); sb_q.push_back(4'd15);
        sb_q.push_back(4'd0); sb_q.push_back(4'd15);
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b1) begin n_err++; $display("FAIL rr_first: got vld=%b, required 1", gnt_vld); end
        for (int r = 0; r < 4; r++) begin
            g = gnt_idx;
            tick(); tick();
            req[g] = 1'b0;
            if (r == 3) req = 16'h0;
            tick();
            if (r < 3) req[g] = 1'b1;
            @(negedge clk);
            n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL rr_gap%0d: got vld=%b, required 0", r, gnt_vld); end
            tick(); @(negedge clk);
            n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL rr_idle%0d: got vld=%b, required 0", r, gnt_vld); end
            if (r < 3) begin
                tick(); @(negedge clk);
                n_cmp++; if (gnt_vld !== 1'b1) begin n_err++; $display("FAIL rr_regrant%0d: got vld=%b, required 1", r, gnt_vld); end
            end
        end
    endtask

    task automatic test_wrap();
        int bad;
        tick();
        req = 16'h0003;
        sb_q.push_back(4'd0);
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b1 || gnt_idx !== 4'd0) begin
            n_err++; $display("FAIL wrap16: got vld=%b idx=%0d, required 1/0", gnt_vld, gnt_idx);
        end
        tick(); req = 16'h0;
        tick(); tick();
        req2 = 16'h0200;
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 4'd9 || gnt2 !== 16'h0200) begin
            n_err++; $display("FAIL wrap10_grant: got vld=%b idx=%0d gnt=%h, required 1/9/0200", gnt_vld2, gnt_idx2, gnt2);
        end
        tick(); req2 = 16'h0;
        tick(); tick();
        req2 = 16'h1000;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick(); @(negedge clk);
            if (gnt_vld2 !== 1'b0 || gnt2 !== 16'h0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wrap10_oob: got %0d granted cycles, required 0", bad); end
        req2 = 16'h0;
    endtask

    task automatic test_hold_timeout();
        do_reset();
        req = 16'h0088;
        sb_q.push_back(4'd3);
`ifdef HOLD_TIMEOUT_EN
        sb_q.push_back(4'd7);
        for (int c = 1; c <= 4; c++) begin
            tick(); @(negedge clk);
            n_cmp++; if (gnt_vld !== 1'b1 || gnt_idx !== 4'd3 || preempt !== 1'b0) begin
                n_err++; $display("FAIL hold_c%0d: got vld=%b idx=%0d pre=%b, required 1/3/0", c, gnt_vld, gnt_idx, preempt);
            end
        end
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b0 || preempt !== 1'b1) begin
            n_err++; $display("FAIL hold_preempt: got vld=%b pre=%b, required 0/1", gnt_vld, preempt);
        end
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b0 || preempt !== 1'b0) begin
            n_err++; $display("FAIL hold_pulse: got vld=%b pre=%b, required 0/0", gnt_vld, preempt);
        end
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b1 || gnt_idx !== 4'd7) begin
            n_err++; $display("FAIL hold_next: got vld=%b idx=%0d, required 1/7", gnt_vld, gnt_idx);
        end
`else
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 20; c++) begin
                tick(); @(negedge clk);
                if (gnt_vld !== 1'b1 || gnt_idx !== 4'd3 || preempt !== 1'b0) bad++;
            end
            n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_forever: got %0d bad cycles, required 0", bad); end
        end
`endif
        tick(); req = 16'h0;
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 16'h0200;
        sb_q.push_back(4'd9);
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b1 || gnt_idx !== 4'd9) begin
            n_err++; $display("FAIL arst_grant: got vld=%b idx=%0d, required 1/9", gnt_vld, gnt_idx);
        end
        #2 rst = 1'b1;
        req = 16'h0;
        #1;
        n_cmp++; if (gnt_vld !== 1'b0 || gnt !== 16'h0) begin
            n_err++; $display("FAIL arst_drop: got vld=%b gnt=%h, required 0/0000", gnt_vld, gnt);
        end
        #1 rst = 1'b0;
        tick();
        req = 16'h0201;
        sb_q.push_back(4'd0);
        tick(); @(negedge clk);
        n_cmp++; if (gnt_vld !== 1'b1 || gnt_idx !== 4'd0) begin
            n_err++; $display("FAIL arst_ptr: got vld=%b idx=%0d, required 1/0", gnt_vld, gnt_idx);
        end
        tick(); req = 16'h0;
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_hold_timeout();
        test_async_reset();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d grants outstanding, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
